ddr2_cmd_sequencer: RTL



---
 rtl/ddr2_cmd_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ddr2_cmd_sequencer.sv
// DDR2 command pad sequencer: holds ACT/PRE/REF/RD/WR requests until per-bank tRP/tRAS/tRCD are met, drives registered pads.
// Optional macro DDR2_SEQ_TRFC_ENFORCE_EN adds a REF-to-REF tRFC gate once a REF has been issued.
module ddr2_cmd_sequencer #(
  parameter int TRCD_MIN = 4,
  parameter int TRP_MIN  = 4,
  parameter int TRAS_MIN = 8,
  parameter int TRFC_MIN = 16,
  parameter int ADDR_W   = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_cmd,
  input  logic [1:0]        req_ba,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              cke_pad,
  output logic              csbar_pad,
  output logic              rasbar_pad,
  output logic              casbar_pad,
  output logic              webar_pad,
  output logic [1:0]        ba_pad,
  output logic [ADDR_W-1:0] addr_pad,
  output logic [3:0]        bank_open,
  output logic              err_illegal
);

  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_PRE = 3'd2;
  localparam logic [2:0] CMD_REF = 3'd3;
  localparam logic [2:0] CMD_RD  = 3'd4;
  localparam logic [2:0] CMD_WR  = 3'd5;

  localparam logic [7:0] TRCD_C = 8'(TRCD_MIN);
  localparam logic [7:0] TRP_C  = 8'(TRP_MIN);
  localparam logic [7:0] TRAS_C = 8'(TRAS_MIN);

  // Timers saturate, so a minimum beyond the timer range could never be met.
  if (TRCD_MIN > 255 || TRP_MIN > 255 || TRAS_MIN > 255 || TRFC_MIN > 65535) begin : g_param_check
    $error("ddr2_cmd_sequencer: timing minimum exceeds timer range");
  end

  typedef enum logic {
    ST_PWRUP = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [7:0] since_act   [4];
  logic [7:0] since_pre   [4];
  logic [7:0] active_time [4];

  logic       sel_open;
  logic       trp_all;
  logic       trfc_ok;
  logic       is_illegal;
  logic       timing_ok;
  logic       accept;
  logic       issue;
  logic [3:0] bank_sel;
  logic [3:0] act_hit;
  logic [3:0] pre_hit;
  logic       ref_hit;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [2:0] pad_code(input logic [2:0] cmd);
    case (cmd)
      CMD_ACT: return 3'b011;
      CMD_PRE: return 3'b010;
      CMD_REF: return 3'b001;
      CMD_RD:  return 3'b101;
      CMD_WR:  return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  // Power-up: one clock with cke low after reset before any command.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_PWRUP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_PWRUP: state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_PWRUP;
    endcase
  end

  assign cke_pad = (state == ST_RUN);

`ifdef DDR2_SEQ_TRFC_ENFORCE_EN
  localparam logic [15:0] TRFC_C = 16'(TRFC_MIN);
  logic [15:0] since_ref;
  logic        ref_seen;

  always_ff @(posedge clk) begin
    if (reset) begin
      since_ref <= '0;
      ref_seen  <= 1'b0;
    end else if (ref_hit) begin
      since_ref <= '0;
      ref_seen  <= 1'b1;
    end else if (since_ref != 16'hFFFF) begin
      since_ref <= since_ref + 16'd1;
    end
  end

  assign trfc_ok = !ref_seen || (since_ref >= TRFC_C);
`else
  assign trfc_ok = 1'b1;
`endif

  assign sel_open = bank_open[req_ba];

  always_comb begin
    trp_all = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (since_pre[b] < TRP_C) trp_all = 1'b0;
    end
  end

  // Illegal requests are ready regardless of timers so they never stall the requester.
  always_comb begin
    is_illegal = 1'b0;
    timing_ok  = 1'b0;
    case (req_cmd)
      CMD_ACT: begin
        if (sel_open) is_illegal = 1'b1;
        else          timing_ok  = (since_pre[req_ba] >= TRP_C);
      end
      CMD_PRE: timing_ok = !sel_open || (active_time[req_ba] >= TRAS_C);
      CMD_REF: begin
        if (bank_open != 4'b0000) is_illegal = 1'b1;
        else                      timing_ok  = trp_all && trfc_ok;
      end
      CMD_RD, CMD_WR: begin
        if (!sel_open) is_illegal = 1'b1;
        else           timing_ok  = (since_act[req_ba] >= TRCD_C);
      end
      default: timing_ok = 1'b1;
    endcase
  end

  assign req_ready = cke_pad && !reset && (is_illegal || timing_ok);
  assign accept    = req_valid && req_ready;
  assign issue     = accept && !is_illegal &&
                     (req_cmd inside {CMD_ACT, CMD_PRE, CMD_REF, CMD_RD, CMD_WR});

  assign bank_sel = 4'b0001 << req_ba;
  assign act_hit  = (issue && req_cmd == CMD_ACT) ? bank_sel : 4'b0000;
  assign pre_hit  = (issue && req_cmd == CMD_PRE) ? bank_sel : 4'b0000;
  assign ref_hit  = issue && (req_cmd == CMD_REF);

  // Clearing at the handshake edge makes each timer read 0 while its command is on the pads.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 4; b++) begin
        since_act[b]   <= '0;
        since_pre[b]   <= '0;
        active_time[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        since_act[b] <= act_hit[b] ? 8'd0 : sat_inc8(since_act[b]);
        since_pre[b] <= pre_hit[b] ? 8'd0 : sat_inc8(since_pre[b]);
        if (act_hit[b])        active_time[b] <= 8'd0;
        else if (bank_open[b]) active_time[b] <= sat_inc8(active_time[b]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csbar_pad   <= 1'b1;
      rasbar_pad  <= 1'b1;
      casbar_pad  <= 1'b1;
      webar_pad   <= 1'b1;
      ba_pad      <= '0;
      addr_pad    <= '0;
      bank_open   <= '0;
      err_illegal <= 1'b0;
    end else begin
      csbar_pad   <= 1'b0;
      err_illegal <= accept && is_illegal;
      bank_open   <= (bank_open | act_hit) & ~pre_hit;
      if (issue) begin
        {rasbar_pad, casbar_pad, webar_pad} <= pad_code(req_cmd);
        // REF carries no bank or address; the pads keep their previous values.
        if (req_cmd != CMD_REF) begin
          ba_pad   <= req_ba;
          addr_pad <= req_addr;
        end
      end else begin
        {rasbar_pad, casbar_pad, webar_pad} <= 3'b111;
      end
    end
  end

endmodule
